serial_adder: RTL

Parametrised bit-serial adder/subtractor for the Lab5 arithmetic datapath. It adds or subtracts two WIDTH-bit operands one bit per clock through a single full-adder slice and a carry flip-flop, trading latency for area. The block uses a start/busy/done handshake and reports carry-out and signed overflow. It sits behind the operand registers and feeds the result display/register stage.

---
 rtl/serial_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation; sum/cout/ovf hold until the next result.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic w_s;
    logic w_c_next;
    logic w_last;

    assign w_s      = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    assign w_c_next = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
    assign w_last   = (r_count == CW'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_count <= '0;
                    end
                end
                S_SHIFT: begin
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_carry <= w_c_next;
                    r_count <= r_count + CW'(1);
                    // On the MSB slice r_carry is the carry into the MSB.
                    if (w_last) begin
                        r_sum  <= {w_s, r_res[WIDTH-1:1]};
                        r_cout <= w_c_next;
                        r_ovf  <= r_carry ^ w_c_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
